// File: rtl/match_score_ctrl.sv
// match_score_ctrl: match-level controller for two BCD win counters.
//
// Takes per-round win pulses from two players, applies them to each player's
// two-digit BCD score and sequences the match through IDLE, PLAY, a post-score
// lockout (LOCK) and OVER. When a player reaches the target score the winner is
// latched and a one-cycle tone request is issued to the speaker block.
//
// Optional feature (macro ROUND_LIMIT_EN): a round counter ends the match after
// MAX_ROUNDS accepted events (decisive or draw). The higher score wins, and
// equal scores give a tie. Without the macro, MAX_ROUNDS is unused.
//
// Ports:
//   clk      in   system clock, posedge
//   rst      in   asynchronous active-high reset
//   start    in   pulse, starts a new match from IDLE or OVER
//   abort    in   level, forces IDLE (scores and winner held)
//   win_p1   in   pulse, player 1 won the round
//   win_p2   in   pulse, player 2 won the round
//   p1_ones  out  player 1 ones BCD digit
//   p1_tens  out  player 1 tens BCD digit
//   p2_ones  out  player 2 ones BCD digit
//   p2_tens  out  player 2 tens BCD digit
//   state    out  0=IDLE 1=PLAY 2=LOCK 3=OVER
//   winner   out  0=none 1=P1 2=P2 3=tie
//   tone_req out  one-cycle pulse in the first OVER cycle
//   busy     out  high in PLAY or LOCK
module match_score_ctrl #(
  parameter int unsigned TARGET_TENS = 2,
  parameter int unsigned TARGET_ONES = 1,
  parameter int unsigned LOCK_CYCLES = 4,
  parameter int unsigned MAX_ROUNDS  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       win_p1,
  input  logic       win_p2,
  output logic [3:0] p1_ones,
  output logic [3:0] p1_tens,
  output logic [3:0] p2_ones,
  output logic [3:0] p2_tens,
  output logic [1:0] state,
  output logic [1:0] winner,
  output logic       tone_req,
  output logic       busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StLock = 2'd2,
    StOver = 2'd3
  } state_e;

  localparam logic [7:0] Target = {4'(TARGET_TENS), 4'(TARGET_ONES)};
  localparam bit LockEn = (LOCK_CYCLES != 0);
  localparam int unsigned LockW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  // The counter holds the number of LOCK cycles still to follow the current one.
  localparam logic [LockW-1:0] LockLoad = LockEn ? LockW'(LOCK_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [7:0]       p1_q, p1_d;     // {tens, ones}
  logic [7:0]       p2_q, p2_d;
  logic [1:0]       winner_q, winner_d;
  logic             tone_q, tone_d;
  logic             busy_q, busy_d;
  logic [LockW-1:0] lock_q, lock_d;

  logic       round_event;   // decisive or draw event accepted in PLAY
  logic       round_clear;   // new match started
  logic       limit_hit;     // this event exhausts the round budget
  logic [7:0] p1_inc, p2_inc;

  // BCD increment of a two-digit score; holds at the target so a score never
  // runs past it.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s == Target) begin
      r = s;
    end else if (s[3:0] == 4'd9) begin
      r = {s[7:4] + 4'd1, 4'd0};
    end else begin
      r = {s[7:4], s[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Tie-break for a match that ends on the round limit; BCD digits compare
  // numerically when taken as one 8-bit value.
  function automatic logic [1:0] lead(input logic [7:0] a, input logic [7:0] b);
    logic [1:0] r;
    if (a > b) begin
      r = 2'd1;
    end else if (a < b) begin
      r = 2'd2;
    end else begin
      r = 2'd3;
    end
    return r;
  endfunction

`ifdef ROUND_LIMIT_EN
  localparam int unsigned RoundW = $clog2(MAX_ROUNDS + 1);

  logic [RoundW-1:0] rounds_q, rounds_d;

  assign limit_hit = ((rounds_q + 1'b1) == RoundW'(MAX_ROUNDS));

  always_comb begin
    rounds_d = rounds_q;
    if (round_clear) begin
      rounds_d = '0;
    end else if (round_event) begin
      rounds_d = rounds_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rounds_q <= '0;
    end else begin
      rounds_q <= rounds_d;
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  assign p1_inc = bcd_inc(p1_q);
  assign p2_inc = bcd_inc(p2_q);

  always_comb begin
    state_d     = state_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    winner_d    = winner_q;
    tone_d      = 1'b0;
    lock_d      = lock_q;
    round_event = 1'b0;
    round_clear = 1'b0;

    if (abort) begin
      state_d = StIdle;
      lock_d  = '0;
    end else begin
      unique case (state_q)
        StIdle, StOver: begin
          if (start) begin
            state_d     = StPlay;
            p1_d        = '0;
            p2_d        = '0;
            winner_d    = 2'd0;
            round_clear = 1'b1;
          end
        end

        StPlay: begin
          if (win_p1 ^ win_p2) begin
            round_event = 1'b1;
            if (win_p1) begin
              p1_d = p1_inc;
            end else begin
              p2_d = p2_inc;
            end
            if (win_p1 && (p1_inc == Target)) begin
              state_d  = StOver;
              winner_d = 2'd1;
              tone_d   = 1'b1;
            end else if (win_p2 && (p2_inc == Target)) begin
              state_d  = StOver;
              winner_d = 2'd2;
              tone_d   = 1'b1;
            end else if (limit_hit) begin
              state_d  = StOver;
              winner_d = win_p1 ? lead(p1_inc, p2_q) : lead(p1_q, p2_inc);
              tone_d   = 1'b1;
            end else if (LockEn) begin
              state_d = StLock;
              lock_d  = LockLoad;
            end
          end else if (win_p1 && win_p2) begin
            // Draw: no score change, but it still uses up a round.
            round_event = 1'b1;
            if (limit_hit) begin
              state_d  = StOver;
              winner_d = lead(p1_q, p2_q);
              tone_d   = 1'b1;
            end
          end
        end

        StLock: begin
          // Win pulses are dropped here, not queued.
          if (lock_q == '0) begin
            state_d = StPlay;
          end else begin
            lock_d = lock_q - 1'b1;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end

    busy_d = (state_d == StPlay) || (state_d == StLock);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      p1_q     <= '0;
      p2_q     <= '0;
      winner_q <= 2'd0;
      tone_q   <= 1'b0;
      busy_q   <= 1'b0;
      lock_q   <= '0;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      winner_q <= winner_d;
      tone_q   <= tone_d;
      busy_q   <= busy_d;
      lock_q   <= lock_d;
    end
  end

  assign p1_tens  = p1_q[7:4];
  assign p1_ones  = p1_q[3:0];
  assign p2_tens  = p2_q[7:4];
  assign p2_ones  = p2_q[3:0];
  assign state    = state_q;
  assign winner   = winner_q;
  assign tone_req = tone_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_match_score_ctrl.sv
// Testbench for match_score_ctrl: directed scenarios with literal expectations,
// then randomized win/start/abort traffic checked every cycle against an
// integer-score reference model.
module tb_match_score_ctrl;

  localparam int unsigned TT = 2;
  localparam int unsigned TO = 1;
  localparam int unsigned LC = 4;
  localparam int unsigned MR = 3;
  localparam int Target = TT * 10 + TO;
`ifdef ROUND_LIMIT_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, win_p1, win_p2;
  logic [3:0] p1_ones, p1_tens, p2_ones, p2_tens;
  logic [1:0] state, winner;
  logic       tone_req, busy;

  match_score_ctrl #(
    .TARGET_TENS(TT),
    .TARGET_ONES(TO),
    .LOCK_CYCLES(LC),
    .MAX_ROUNDS (MR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .win_p1  (win_p1),
    .win_p2  (win_p2),
    .p1_ones (p1_ones),
    .p1_tens (p1_tens),
    .p2_ones (p2_ones),
    .p2_tens (p2_tens),
    .state   (state),
    .winner  (winner),
    .tone_req(tone_req),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: scores as plain integers 0..99, state as 0..3.
  int m_p1, m_p2, m_state, m_win, m_tone, m_lock, m_rounds;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p1 = 0; m_p2 = 0; m_state = 0; m_win = 0; m_tone = 0; m_lock = 0; m_rounds = 0;
    end else begin
      m_tone = 0;
      if (abort) begin
        m_state = 0;
        m_lock  = 0;
      end else if (m_state == 0 || m_state == 3) begin
        if (start) begin
          m_p1 = 0; m_p2 = 0; m_win = 0; m_state = 1; m_rounds = 0;
        end
      end else if (m_state == 2) begin
        m_lock--;
        if (m_lock == 0) m_state = 1;
      end else if (win_p1 || win_p2) begin
        if (win_p1 && !win_p2) m_p1++;
        if (win_p2 && !win_p1) m_p2++;
        m_rounds++;
        if (win_p1 && !win_p2 && m_p1 == Target) begin
          m_state = 3; m_win = 1; m_tone = 1;
        end else if (win_p2 && !win_p1 && m_p2 == Target) begin
          m_state = 3; m_win = 2; m_tone = 1;
        end else if (RoundEn && m_rounds == MR) begin
          m_state = 3; m_tone = 1;
          m_win = (m_p1 > m_p2) ? 1 : (m_p1 < m_p2) ? 2 : 3;
        end else if ((win_p1 != win_p2) && LC > 0) begin
          m_state = 2; m_lock = LC;
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("p1_ones", p1_ones, m_p1 % 10);
    chk("p1_tens", p1_tens, m_p1 / 10);
    chk("p2_ones", p2_ones, m_p2 % 10);
    chk("p2_tens", p2_tens, m_p2 / 10);
    chk("state", state, m_state);
    chk("winner", winner, m_win);
    chk("tone_req", tone_req, m_tone);
    chk("busy", busy, (m_state == 1 || m_state == 2) ? 1 : 0);
  end

  // Drive a one-cycle input pattern starting at a negedge.
  task automatic pulse(input logic w1, input logic w2, input logic s, input logic a);
    win_p1 = w1; win_p2 = w2; start = s; abort = a;
    @(negedge clk);
    win_p1 = 1'b0; win_p2 = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  // Count LOCK cycles (bounded); optionally inject a win_p1 inside the window.
  task automatic wait_lock(input string name, input bit inject);
    int n = 0;
    while (state == 2'd2 && n < 3 * LC + 4) begin
      n++;
      win_p1 = (inject && n == 2);
      @(negedge clk);
    end
    win_p1 = 1'b0;
    chk(name, n, LC);
  endtask

  initial begin
    int r;
    rst = 1'b1; start = 1'b0; abort = 1'b0; win_p1 = 1'b0; win_p2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", state, 0);
    chk("reset_busy", busy, 0);
    chk("reset_p1", {p1_tens, p1_ones}, 0);

    pulse(0, 0, 1, 0);
    chk("start_state", state, 1);
    chk("start_busy", busy, 1);

`ifndef ROUND_LIMIT_EN
    // Ten spaced P1 wins; one extra pulse lands inside the third lockout.
    for (int k = 1; k <= 10; k++) begin
      pulse(1, 0, 0, 0);
      chk("p1_step", p1_tens * 10 + p1_ones, k);
      chk("lock_entered", state, 2);
      wait_lock("lock_len", k == 3);
    end
    chk("p1_tens_10", p1_tens, 1);
    chk("p1_ones_10", p1_ones, 0);

    pulse(1, 1, 0, 0);
    chk("draw_state", state, 1);
    chk("draw_p1", {p1_tens, p1_ones}, 8'h10);
    chk("draw_p2", {p2_tens, p2_ones}, 8'h00);

    for (int k = 1; k <= 20; k++) begin
      pulse(0, 1, 0, 0);
      wait_lock("p2_lock_len", 1'b0);
    end
    chk("p2_at_20", {p2_tens, p2_ones}, 8'h20);
    pulse(0, 1, 0, 0);
    chk("p2_21", {p2_tens, p2_ones}, 8'h21);
    chk("over_state", state, 3);
    chk("over_winner", winner, 2);
    chk("over_tone", tone_req, 1);
    @(negedge clk);
    chk("tone_one_cycle", tone_req, 0);
    pulse(0, 1, 0, 0);
    chk("over_frozen", {p2_tens, p2_ones}, 8'h21);
    pulse(0, 0, 1, 0);
    chk("restart_state", state, 1);
    chk("restart_p2", {p2_tens, p2_ones}, 8'h00);
`endif

    // Round-limit stimulus: P1 win, P2 win, draw.
    pulse(0, 0, 0, 1);
    chk("abort_state", state, 0);
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    wait_lock("rl_lock1", 1'b0);
    pulse(0, 1, 0, 0);
    wait_lock("rl_lock2", 1'b0);
    pulse(1, 1, 0, 0);
`ifdef ROUND_LIMIT_EN
    chk("limit_state", state, 3);
    chk("limit_winner", winner, 3);
    chk("limit_tone", tone_req, 1);
    @(negedge clk);
    chk("limit_tone_off", tone_req, 0);
    pulse(0, 0, 1, 0);
`else
    chk("nolimit_state", state, 1);
    chk("nolimit_winner", winner, 0);
`endif

    // Asynchronous reset mid-match, no clock edge in between.
    pulse(1, 0, 0, 0);
    wait_lock("pre_rst_lock", 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_state", state, 0);
    chk("async_p1", {p1_tens, p1_ones}, 0);
    chk("async_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      win_p1 = ($urandom_range(0, 99) < 40);
      win_p2 = ($urandom_range(0, 99) < 40);
      r = $urandom_range(0, 99);
      start = (state == 2'd0 || state == 2'd3) ? (r < 30) : (r < 3);
      abort = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    win_p1 = 1'b0; win_p2 = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
